// File: rtl/sdram_client_arbiter.sv
// Shares one SDRAM controller port between a real-time display reader (D) and a
// compute engine (C). C owns the port by default; D takes it via request/yield.
module sdram_client_arbiter #(
  parameter int ADDR_W       = 22,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 1024,
  parameter int CNT_W        = 16
) (
  input  logic              i_Clk,
  input  logic              i_Reset,
  input  logic              i_Disp_Req,
  output logic              o_Disp_Grant,
  input  logic [1:0]        i_Disp_Command,
  input  logic [ADDR_W-1:0] i_Disp_Address,
  input  logic [DATA_W-1:0] i_Disp_Write,
  output logic              o_Disp_Read_Valid,
  output logic              o_Disp_Write_Done,
  output logic              o_Cmp_Requested,
  input  logic              i_Cmp_Yield,
  input  logic [1:0]        i_Cmp_Command,
  input  logic [ADDR_W-1:0] i_Cmp_Address,
  input  logic [DATA_W-1:0] i_Cmp_Write,
  output logic              o_Cmp_Read_Valid,
  output logic              o_Cmp_Write_Done,
  output logic [1:0]        o_Command,
  output logic [ADDR_W-1:0] o_Data_Address,
  output logic [DATA_W-1:0] o_Data_Write,
  input  logic              i_Data_Read_Valid,
  input  logic              i_Data_Write_Done,
  input  logic              i_Ctrl_Idle,
  output logic              o_Starve,
  output logic [CNT_W-1:0]  o_Disp_Grants,
  output logic [1:0]        o_State
);

  localparam logic [1:0] CMD_IDLE = 2'd0;

  localparam logic [1:0] S_CMP  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DISP = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  localparam int WCNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [WCNT_W-1:0] LIMIT = WCNT_W'(STARVE_LIMIT);

  logic [1:0]        state;
  logic [WCNT_W-1:0] wait_cnt;
  logic              disp_exit;

  // D's tenure only ends once nothing of its own is left in the controller.
  assign disp_exit = !i_Disp_Req && (i_Disp_Command == CMD_IDLE) && i_Ctrl_Idle;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state         <= S_CMP;
      wait_cnt      <= '0;
      o_Starve      <= 1'b0;
      o_Disp_Grants <= '0;
    end else begin
      case (state)
        S_CMP: begin
          wait_cnt <= '0;
          if (i_Disp_Req) state <= S_WAIT;
        end
        S_WAIT: begin
          if (!i_Disp_Req) begin
            state    <= S_CMP;
            wait_cnt <= '0;
          end else if (i_Cmp_Yield && i_Ctrl_Idle) begin
            state         <= S_DISP;
            wait_cnt      <= '0;
            o_Disp_Grants <= o_Disp_Grants + 1'b1;
          end else begin
            if (wait_cnt != LIMIT) wait_cnt <= wait_cnt + 1'b1;
            // Latches in the same cycle the counter arrives at the limit.
            if (wait_cnt >= LIMIT - 1'b1) o_Starve <= 1'b1;
          end
        end
        S_DISP: begin
          if (disp_exit) state <= S_GAP;
        end
        default: state <= S_CMP;
      endcase
    end
  end

  assign o_State         = state;
  assign o_Disp_Grant    = (state == S_DISP);
  assign o_Cmp_Requested = (state == S_WAIT) || (state == S_DISP);

  always_comb begin
    o_Command         = i_Cmp_Command;
    o_Data_Address    = i_Cmp_Address;
    o_Data_Write      = i_Cmp_Write;
    o_Cmp_Read_Valid  = 1'b0;
    o_Cmp_Write_Done  = 1'b0;
    o_Disp_Read_Valid = 1'b0;
    o_Disp_Write_Done = 1'b0;
    case (state)
      S_CMP, S_WAIT: begin
        o_Cmp_Read_Valid = i_Data_Read_Valid;
        o_Cmp_Write_Done = i_Data_Write_Done;
      end
      S_DISP: begin
        o_Command         = i_Disp_Command;
        o_Data_Address    = i_Disp_Address;
        o_Data_Write      = i_Disp_Write;
        o_Disp_Read_Valid = i_Data_Read_Valid;
        o_Disp_Write_Done = i_Data_Write_Done;
      end
      default: o_Command = CMD_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sdram_client_arbiter.sv
// Directed bench for sdram_client_arbiter: handover, busy C, release, starvation,
// reset mid-tenure, withdraw and grant-counter wrap.
module tb_sdram_client_arbiter;

  localparam int ADDR_W = 22;
  localparam int DATA_W = 32;
  localparam int LIM    = 16;
  localparam int CNT_W  = 4;

  localparam int S_CMP  = 0;
  localparam int S_WAIT = 1;
  localparam int S_DISP = 2;
  localparam int S_GAP  = 3;
  localparam int C_IDLE = 0;
  localparam int C_READ = 1;
  localparam int C_WRT  = 2;

  localparam int C_ADDR = 'h123;
  localparam int C_DATA = 'hC0C0;
  localparam int D_ADDR = 'h3AB;
  localparam int D_DATA = 'hD0D0;

  logic              i_Clk = 1'b0;
  logic              i_Reset;
  logic              i_Disp_Req;
  logic              o_Disp_Grant;
  logic [1:0]        i_Disp_Command;
  logic [ADDR_W-1:0] i_Disp_Address;
  logic [DATA_W-1:0] i_Disp_Write;
  logic              o_Disp_Read_Valid;
  logic              o_Disp_Write_Done;
  logic              o_Cmp_Requested;
  logic              i_Cmp_Yield;
  logic [1:0]        i_Cmp_Command;
  logic [ADDR_W-1:0] i_Cmp_Address;
  logic [DATA_W-1:0] i_Cmp_Write;
  logic              o_Cmp_Read_Valid;
  logic              o_Cmp_Write_Done;
  logic [1:0]        o_Command;
  logic [ADDR_W-1:0] o_Data_Address;
  logic [DATA_W-1:0] o_Data_Write;
  logic              i_Data_Read_Valid;
  logic              i_Data_Write_Done;
  logic              i_Ctrl_Idle;
  logic              o_Starve;
  logic [CNT_W-1:0]  o_Disp_Grants;
  logic [1:0]        o_State;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 i_Clk = ~i_Clk;

  sdram_client_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(LIM), .CNT_W(CNT_W)
  ) dut (
    .i_Clk(i_Clk), .i_Reset(i_Reset),
    .i_Disp_Req(i_Disp_Req), .o_Disp_Grant(o_Disp_Grant),
    .i_Disp_Command(i_Disp_Command), .i_Disp_Address(i_Disp_Address),
    .i_Disp_Write(i_Disp_Write), .o_Disp_Read_Valid(o_Disp_Read_Valid),
    .o_Disp_Write_Done(o_Disp_Write_Done), .o_Cmp_Requested(o_Cmp_Requested),
    .i_Cmp_Yield(i_Cmp_Yield), .i_Cmp_Command(i_Cmp_Command),
    .i_Cmp_Address(i_Cmp_Address), .i_Cmp_Write(i_Cmp_Write),
    .o_Cmp_Read_Valid(o_Cmp_Read_Valid), .o_Cmp_Write_Done(o_Cmp_Write_Done),
    .o_Command(o_Command), .o_Data_Address(o_Data_Address),
    .o_Data_Write(o_Data_Write), .i_Data_Read_Valid(i_Data_Read_Valid),
    .i_Data_Write_Done(i_Data_Write_Done), .i_Ctrl_Idle(i_Ctrl_Idle),
    .o_Starve(o_Starve), .o_Disp_Grants(o_Disp_Grants), .o_State(o_State)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Inputs change and outputs are sampled 1ns after the active edge.
  task automatic tick();
    @(posedge i_Clk);
    #1;
  endtask

  initial begin
    i_Reset = 1'b1; i_Disp_Req = 1'b0; i_Cmp_Yield = 1'b0; i_Ctrl_Idle = 1'b1;
    i_Disp_Command = 2'(C_READ); i_Disp_Address = ADDR_W'(D_ADDR); i_Disp_Write = DATA_W'(D_DATA);
    i_Cmp_Command = 2'(C_WRT); i_Cmp_Address = ADDR_W'(C_ADDR); i_Cmp_Write = DATA_W'(C_DATA);
    i_Data_Read_Valid = 1'b0; i_Data_Write_Done = 1'b0;
    tick(); tick();
    i_Reset = 1'b0;
    #1;
    chk("rst_state", 32'(o_State), S_CMP);
    chk("rst_grant", 32'(o_Disp_Grant), 0);
    chk("rst_req", 32'(o_Cmp_Requested), 0);
    chk("rst_grants", 32'(o_Disp_Grants), 0);
    chk("rst_starve", 32'(o_Starve), 0);
    chk("cmp_cmd", 32'(o_Command), C_WRT);
    chk("cmp_addr", 32'(o_Data_Address), C_ADDR);
    chk("cmp_data", 32'(o_Data_Write), C_DATA);
    i_Data_Read_Valid = 1'b1;
    #1;
    chk("cmp_rv_c", 32'(o_Cmp_Read_Valid), 1);
    chk("cmp_rv_d", 32'(o_Disp_Read_Valid), 0);
    i_Data_Read_Valid = 1'b0;

    // Handover with C already yielding and the controller idle
    i_Cmp_Yield = 1'b1; i_Disp_Req = 1'b1;
    tick();
    chk("t2_c1_state", 32'(o_State), S_WAIT);
    chk("t2_c1_req", 32'(o_Cmp_Requested), 1);
    chk("t2_c1_grant", 32'(o_Disp_Grant), 0);
    chk("t2_c1_cmd", 32'(o_Command), C_WRT);
    tick();
    chk("t2_c2_grant", 32'(o_Disp_Grant), 1);
    chk("t2_c2_req", 32'(o_Cmp_Requested), 1);
    chk("t2_c2_cmd", 32'(o_Command), C_READ);
    chk("t2_c2_addr", 32'(o_Data_Address), D_ADDR);
    chk("t2_c2_data", 32'(o_Data_Write), D_DATA);
    chk("t2_c2_grants", 32'(o_Disp_Grants), 1);
    i_Data_Read_Valid = 1'b1; i_Data_Write_Done = 1'b1;
    #1;
    chk("t2_rv_d", 32'(o_Disp_Read_Valid), 1);
    chk("t2_wd_d", 32'(o_Disp_Write_Done), 1);
    chk("t2_rv_c", 32'(o_Cmp_Read_Valid), 0);
    chk("t2_wd_c", 32'(o_Cmp_Write_Done), 0);

    // Release while the controller is still busy for 3 cycles
    i_Disp_Req = 1'b0; i_Disp_Command = 2'(C_IDLE); i_Ctrl_Idle = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_hold_grant", 32'(o_Disp_Grant), 1);
    end
    i_Ctrl_Idle = 1'b1;
    tick();
    chk("t4_gap_state", 32'(o_State), S_GAP);
    chk("t4_gap_grant", 32'(o_Disp_Grant), 0);
    chk("t4_gap_req", 32'(o_Cmp_Requested), 0);
    chk("t4_gap_cmd", 32'(o_Command), C_IDLE);
    chk("t4_gap_addr", 32'(o_Data_Address), C_ADDR);
    chk("t4_gap_rv_c", 32'(o_Cmp_Read_Valid), 0);
    chk("t4_gap_rv_d", 32'(o_Disp_Read_Valid), 0);
    chk("t4_gap_wd_c", 32'(o_Cmp_Write_Done), 0);
    tick();
    chk("t4_cmp_state", 32'(o_State), S_CMP);
    chk("t4_cmp_cmd", 32'(o_Command), C_WRT);
    chk("t4_cmp_rv_c", 32'(o_Cmp_Read_Valid), 1);
    i_Data_Read_Valid = 1'b0; i_Data_Write_Done = 1'b0;

    // C busy: no yield for 8 cycles, controller busy
    i_Disp_Command = 2'(C_READ); i_Cmp_Yield = 1'b0; i_Ctrl_Idle = 1'b0; i_Disp_Req = 1'b1;
    tick();
    i_Data_Write_Done = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t3_state", 32'(o_State), S_WAIT);
      chk("t3_cmd", 32'(o_Command), C_WRT);
      chk("t3_wd_c", 32'(o_Cmp_Write_Done), 1);
      chk("t3_wd_d", 32'(o_Disp_Write_Done), 0);
    end
    chk("t3_starve", 32'(o_Starve), 0);
    i_Data_Write_Done = 1'b0;
    i_Cmp_Yield = 1'b1;
    tick();
    chk("t3_busy_ctrl", 32'(o_Disp_Grant), 0);
    i_Ctrl_Idle = 1'b1;
    tick();
    chk("t3_grant", 32'(o_Disp_Grant), 1);
    chk("t3_grants", 32'(o_Disp_Grants), 2);
    i_Disp_Req = 1'b0; i_Disp_Command = 2'(C_IDLE);
    tick(); tick();
    chk("t3_back_cmp", 32'(o_State), S_CMP);

    // Starvation with limit 16
    i_Disp_Command = 2'(C_READ); i_Cmp_Yield = 1'b0; i_Disp_Req = 1'b1;
    tick();
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("t5_no_starve", 32'(o_Starve), 0);
    end
    tick();
    chk("t5_starve16", 32'(o_Starve), 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_sticky", 32'(o_Starve), 1);
      chk("t5_waiting", 32'(o_State), S_WAIT);
    end
    i_Cmp_Yield = 1'b1;
    tick();
    chk("t5_grant", 32'(o_Disp_Grant), 1);
    chk("t5_after_grant", 32'(o_Starve), 1);
    chk("t5_grants", 32'(o_Disp_Grants), 3);

    // Reset in the middle of a D tenure
    i_Reset = 1'b1;
    tick();
    i_Reset = 1'b0; i_Disp_Req = 1'b0; i_Cmp_Yield = 1'b0;
    chk("t1_state", 32'(o_State), S_CMP);
    chk("t1_grant", 32'(o_Disp_Grant), 0);
    chk("t1_req", 32'(o_Cmp_Requested), 0);
    chk("t1_grants", 32'(o_Disp_Grants), 0);
    chk("t1_starve", 32'(o_Starve), 0);

    // Withdraw in S_WAIT, then yield without a request
    i_Disp_Req = 1'b1;
    tick();
    chk("t6_wait", 32'(o_State), S_WAIT);
    i_Disp_Req = 1'b0;
    tick();
    chk("t6_withdraw", 32'(o_State), S_CMP);
    chk("t6_no_count", 32'(o_Disp_Grants), 0);
    i_Cmp_Yield = 1'b1;
    tick();
    chk("t6_yield_ign", 32'(o_State), S_CMP);
    chk("t6_yield_req", 32'(o_Cmp_Requested), 0);

    // Sixteen grants wrap the 4-bit counter
    i_Disp_Command = 2'(C_IDLE);
    for (int i = 0; i < 16; i++) begin
      i_Disp_Req = 1'b1;
      tick(); tick();
      chk("t6_loop_grant", 32'(o_Disp_Grant), 1);
      i_Disp_Req = 1'b0;
      tick(); tick();
      if (i == 14) chk("t6_grants15", 32'(o_Disp_Grants), 15);
    end
    chk("t6_wrap", 32'(o_Disp_Grants), 0);
    chk("t6_end_state", 32'(o_State), S_CMP);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
